// File: rtl/issue_tracker_if.sv
// Issue-stage tracker bus: allocation, write-back, commit and operand lookup.
// The master side drives requests; the slave side is the tracker itself.
interface issue_tracker_if #(
   parameter int NR_ENTRIES      = 8,
   parameter int NR_WB_PORTS     = 4,
   parameter int NR_COMMIT_PORTS = 2,
   parameter int NR_RS           = 3,
   parameter int XLEN_W          = 64,
   parameter int PAYLOAD_W       = 32
) ();
   localparam int ID_W  = $clog2(NR_ENTRIES);
   localparam int CNT_W = $clog2(NR_ENTRIES + 1);

   logic                                         flush_i;
   logic                                         alloc_valid_i;
   logic                                         alloc_ready_o;
   logic [4:0]                                   alloc_rd_i;
   logic [PAYLOAD_W-1:0]                         alloc_payload_i;
   logic [ID_W-1:0]                              alloc_id_o;
   logic [NR_WB_PORTS-1:0]                       wb_valid_i;
   logic [NR_WB_PORTS-1:0][ID_W-1:0]             wb_id_i;
   logic [NR_WB_PORTS-1:0][XLEN_W-1:0]           wb_data_i;
   logic [NR_COMMIT_PORTS-1:0]                   commit_valid_o;
   logic [NR_COMMIT_PORTS-1:0][4:0]              commit_rd_o;
   logic [NR_COMMIT_PORTS-1:0][XLEN_W-1:0]       commit_data_o;
   logic [NR_COMMIT_PORTS-1:0][PAYLOAD_W-1:0]    commit_payload_o;
   logic [NR_COMMIT_PORTS-1:0]                   commit_ack_i;
   logic [NR_RS-1:0][4:0]                        rs_i;
   logic [NR_RS-1:0]                             rs_busy_o;
   logic [NR_RS-1:0]                             rs_fwd_valid_o;
   logic [NR_RS-1:0][XLEN_W-1:0]                 rs_fwd_data_o;
   logic [CNT_W-1:0]                             usage_o;

   modport master (
      output flush_i, alloc_valid_i, alloc_rd_i, alloc_payload_i,
             wb_valid_i, wb_id_i, wb_data_i, commit_ack_i, rs_i,
      input  alloc_ready_o, alloc_id_o, commit_valid_o, commit_rd_o,
             commit_data_o, commit_payload_o, rs_busy_o, rs_fwd_valid_o,
             rs_fwd_data_o, usage_o
   );

   modport slave (
      input  flush_i, alloc_valid_i, alloc_rd_i, alloc_payload_i,
             wb_valid_i, wb_id_i, wb_data_i, commit_ack_i, rs_i,
      output alloc_ready_o, alloc_id_o, commit_valid_o, commit_rd_o,
             commit_data_o, commit_payload_o, rs_busy_o, rs_fwd_valid_o,
             rs_fwd_data_o, usage_o
   );
endinterface

// File: rtl/issue_tracker.sv
// In-order instruction tracking buffer for the issue stage.
// Entries are allocated at the tail, completed out of order by write-back id,
// and retired from the head in program order. Operand lookups report whether
// a pending producer exists and whether its youngest instance has a result.
// Full and empty are told apart by the occupancy count, never by pointers.
module issue_tracker #(
   parameter int NR_ENTRIES      = 8,
   parameter int NR_WB_PORTS     = 4,
   parameter int NR_COMMIT_PORTS = 2,
   parameter int NR_RS           = 3,
   parameter int XLEN_W          = 64,
   parameter int PAYLOAD_W       = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   issue_tracker_if.slave    bus
);
   localparam int ID_W  = $clog2(NR_ENTRIES);
   localparam int CNT_W = $clog2(NR_ENTRIES + 1);

   logic                  r_valid   [NR_ENTRIES];
   logic                  r_done    [NR_ENTRIES];
   logic [4:0]            r_rd      [NR_ENTRIES];
   logic [PAYLOAD_W-1:0]  r_payload [NR_ENTRIES];
   logic [XLEN_W-1:0]     r_data    [NR_ENTRIES];
   logic [ID_W-1:0]       r_head;
   logic [ID_W-1:0]       r_tail;
   logic [CNT_W-1:0]      r_count;

   logic                        w_alloc_ready;
   logic                        w_alloc_fire;
   logic [CNT_W-1:0]            w_ack_cnt;
   logic [NR_COMMIT_PORTS-1:0]  w_commit_valid;

   // Retires in the same cycle do not free space until the next edge.
   assign w_alloc_ready      = (r_count != CNT_W'(NR_ENTRIES));
   assign w_alloc_fire       = bus.alloc_valid_i & w_alloc_ready;
   assign bus.alloc_ready_o  = w_alloc_ready;
   assign bus.alloc_id_o     = r_tail;
   assign bus.usage_o        = r_count;
   assign bus.commit_valid_o = w_commit_valid;

   // Commit window: the contiguous run of completed entries starting at head.
   always_comb begin
      logic            w_prefix;
      logic [ID_W-1:0] w_idx;
      w_prefix = 1'b1;
      w_idx    = '0;
      for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
         w_idx                   = r_head + ID_W'(k);
         w_prefix                = w_prefix & r_valid[w_idx] & r_done[w_idx];
         w_commit_valid[k]       = w_prefix;
         bus.commit_rd_o[k]      = r_rd[w_idx];
         bus.commit_data_o[k]    = r_data[w_idx];
         bus.commit_payload_o[k] = r_payload[w_idx];
      end
   end

   // Number of entries retired this cycle (acks form a prefix).
   always_comb begin
      w_ack_cnt = '0;
      for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
         w_ack_cnt = w_ack_cnt + CNT_W'(bus.commit_ack_i[k]);
      end
   end

   // Operand lookup: walk oldest to youngest so the last match is the youngest producer.
   always_comb begin
      logic [ID_W-1:0] w_idx;
      w_idx = '0;
      for (int r = 0; r < NR_RS; r++) begin
         bus.rs_busy_o[r]      = 1'b0;
         bus.rs_fwd_valid_o[r] = 1'b0;
         bus.rs_fwd_data_o[r]  = '0;
         if (bus.rs_i[r] != 5'd0) begin
            for (int a = 0; a < NR_ENTRIES; a++) begin
               w_idx = r_head + ID_W'(a);
               if (r_valid[w_idx] && (r_rd[w_idx] == bus.rs_i[r])) begin
                  bus.rs_busy_o[r]      = 1'b1;
                  bus.rs_fwd_valid_o[r] = r_done[w_idx];
                  bus.rs_fwd_data_o[r]  = r_data[w_idx];
               end
            end
         end
      end
   end

   // Entry array and pointer update; flush overrides every other request.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int e = 0; e < NR_ENTRIES; e++) begin
            r_valid[e]   <= 1'b0;
            r_done[e]    <= 1'b0;
            r_rd[e]      <= '0;
            r_payload[e] <= '0;
            r_data[e]    <= '0;
         end
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (bus.flush_i) begin
         for (int e = 0; e < NR_ENTRIES; e++) begin
            r_valid[e] <= 1'b0;
            r_done[e]  <= 1'b0;
         end
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         // Ascending port order: the highest port targeting an id lands last.
         for (int p = 0; p < NR_WB_PORTS; p++) begin
            if (bus.wb_valid_i[p] && r_valid[bus.wb_id_i[p]]) begin
               r_done[bus.wb_id_i[p]] <= 1'b1;
               r_data[bus.wb_id_i[p]] <= bus.wb_data_i[p];
            end
         end
         for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            if (bus.commit_ack_i[k]) begin
               r_valid[r_head + ID_W'(k)] <= 1'b0;
               r_done[r_head + ID_W'(k)]  <= 1'b0;
            end
         end
         // The tail slot is always free when not full, so no collision with the above.
         if (w_alloc_fire) begin
            r_valid[r_tail]   <= 1'b1;
            r_done[r_tail]    <= 1'b0;
            r_rd[r_tail]      <= bus.alloc_rd_i;
            r_payload[r_tail] <= bus.alloc_payload_i;
            r_tail            <= r_tail + ID_W'(1);
         end
         r_head  <= r_head + ID_W'(w_ack_cnt);
         r_count <= r_count + CNT_W'(w_alloc_fire) - w_ack_cnt;
      end
   end

   // Acks must only retire a prefix of the offered commit candidates.
   ack_prefix_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !bus.flush_i |->
         (((bus.commit_ack_i & ~w_commit_valid) == '0) &&
          ((bus.commit_ack_i & (bus.commit_ack_i + NR_COMMIT_PORTS'(1))) == '0)));

endmodule

// File: tb/tb_issue_tracker.sv
// Bench for issue_tracker: a queue-based model checked every cycle, plus
// hand-computed literal expectations along directed scenarios.
module tb_issue_tracker;
   localparam int N    = 8;
   localparam int WB   = 4;
   localparam int CP   = 2;
   localparam int RS   = 3;
   localparam int XL   = 64;
   localparam int PW   = 32;
   localparam int ID_W = $clog2(N);

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_err    = 0;

   issue_tracker_if #(.NR_ENTRIES(N), .NR_WB_PORTS(WB), .NR_COMMIT_PORTS(CP),
                      .NR_RS(RS), .XLEN_W(XL), .PAYLOAD_W(PW)) bus();

   issue_tracker #(.NR_ENTRIES(N), .NR_WB_PORTS(WB), .NR_COMMIT_PORTS(CP),
                   .NR_RS(RS), .XLEN_W(XL), .PAYLOAD_W(PW)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int             id;
      logic [4:0]     rd;
      logic [PW-1:0]  pl;
      bit             done;
      logic [XL-1:0]  data;
   } ent_t;

   ent_t q[$];     // oldest at front
   int   mtail;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Model: instructions live in a program-order queue.
   initial begin
      mtail = 0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n || bus.flush_i) begin
            q.delete();
            mtail = 0;
         end else begin
            bit   rdy;
            int   nack;
            ent_t e;
            rdy = (q.size() < N);
            for (int p = 0; p < WB; p++) begin
               if (bus.wb_valid_i[p]) begin
                  for (int i = 0; i < q.size(); i++) begin
                     if (q[i].id == int'(bus.wb_id_i[p])) begin
                        e = q[i];
                        e.done = 1'b1;
                        e.data = bus.wb_data_i[p];
                        q[i] = e;
                     end
                  end
               end
            end
            nack = $countones(bus.commit_ack_i);
            for (int k = 0; k < nack; k++) begin
               if (q.size() > 0) void'(q.pop_front());
            end
            if (bus.alloc_valid_i && rdy) begin
               e.id   = mtail;
               e.rd   = bus.alloc_rd_i;
               e.pl   = bus.alloc_payload_i;
               e.done = 1'b0;
               e.data = '0;
               q.push_back(e);
               mtail = (mtail + 1) % N;
            end
         end
      end
   end

   // Compare DUT against the model at every falling edge out of reset.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            int   sz;
            bit   prev;
            bit   ev;
            bit   eb;
            bit   ef;
            logic [XL-1:0] ed;
            sz = q.size();
            chk("usage", 64'(bus.usage_o), 64'(sz));
            chk("alloc_ready", 64'(bus.alloc_ready_o), 64'(sz < N));
            chk("alloc_id", 64'(bus.alloc_id_o), 64'(mtail));
            prev = 1'b1;
            for (int k = 0; k < CP; k++) begin
               ev = 1'b0;
               if (prev && k < sz) ev = q[k].done;
               chk($sformatf("commit_valid[%0d]", k), 64'(bus.commit_valid_o[k]), 64'(ev));
               if (ev) begin
                  chk($sformatf("commit_rd[%0d]", k), 64'(bus.commit_rd_o[k]), 64'(q[k].rd));
                  chk($sformatf("commit_data[%0d]", k), bus.commit_data_o[k], q[k].data);
                  chk($sformatf("commit_payload[%0d]", k), 64'(bus.commit_payload_o[k]), 64'(q[k].pl));
               end
               prev = ev;
            end
            for (int r = 0; r < RS; r++) begin
               eb = 1'b0;
               ef = 1'b0;
               ed = '0;
               if (bus.rs_i[r] != 5'd0) begin
                  for (int i = sz - 1; i >= 0; i--) begin
                     if (q[i].rd == bus.rs_i[r]) begin
                        eb = 1'b1;
                        ef = q[i].done;
                        ed = q[i].data;
                        break;
                     end
                  end
               end
               chk($sformatf("rs_busy[%0d]", r), 64'(bus.rs_busy_o[r]), 64'(eb));
               chk($sformatf("rs_fwd_valid[%0d]", r), 64'(bus.rs_fwd_valid_o[r]), 64'(ef));
               if (ef) chk($sformatf("rs_fwd_data[%0d]", r), bus.rs_fwd_data_o[r], ed);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      bus.flush_i       = 1'b0;
      bus.alloc_valid_i = 1'b0;
      bus.wb_valid_i    = '0;
      bus.wb_id_i       = '0;
      bus.wb_data_i     = '0;
      bus.commit_ack_i  = '0;
   endtask

   task automatic set_wb(input int p, input int id, input logic [XL-1:0] d);
      bus.wb_valid_i[p] = 1'b1;
      bus.wb_id_i[p]    = ID_W'(id);
      bus.wb_data_i[p]  = d;
   endtask

   task automatic do_alloc(input logic [4:0] rd, input logic [PW-1:0] pl);
      clr_in();
      bus.alloc_valid_i   = 1'b1;
      bus.alloc_rd_i      = rd;
      bus.alloc_payload_i = pl;
      tick();
      clr_in();
   endtask

   task automatic do_flush();
      clr_in();
      bus.flush_i = 1'b1;
      tick();
      clr_in();
   endtask

   initial begin
      rst_n = 1'b0;
      clr_in();
      bus.rs_i            = '0;
      bus.alloc_rd_i      = 5'd5;
      bus.alloc_payload_i = 32'h0000_0005;
      bus.alloc_valid_i   = 1'b1;

      // Reset with alloc held, then first allocation of rd=5
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      #1;
      chk("t1_usage", 64'(bus.usage_o), 64'd0);
      chk("t1_ready", 64'(bus.alloc_ready_o), 64'd1);
      chk("t1_alloc_id", 64'(bus.alloc_id_o), 64'd0);
      chk("t1_commit_valid", 64'(bus.commit_valid_o), 64'd0);
      tick();
      clr_in();
      bus.rs_i[0] = 5'd5;
      #1;
      chk("t1_usage_after", 64'(bus.usage_o), 64'd1);
      chk("t1_busy", 64'(bus.rs_busy_o[0]), 64'd1);
      chk("t1_fwd_valid", 64'(bus.rs_fwd_valid_o[0]), 64'd0);

      // Full tracker: alloc and ack together, alloc is rejected
      do_flush();
      for (int i = 0; i < N; i++) do_alloc(5'(i + 1), 32'hC0DE_0000 + 32'(i));
      set_wb(0, 0, 64'h77);
      tick();
      clr_in();
      chk("t2_usage_full", 64'(bus.usage_o), 64'd8);
      chk("t2_ready_full", 64'(bus.alloc_ready_o), 64'd0);
      chk("t2_commit_valid", 64'(bus.commit_valid_o), 64'd1);
      bus.alloc_valid_i   = 1'b1;
      bus.alloc_rd_i      = 5'd20;
      bus.alloc_payload_i = 32'hDEAD;
      bus.commit_ack_i    = 2'b01;
      #1;
      chk("t2_ready_same_cycle", 64'(bus.alloc_ready_o), 64'd0);
      tick();
      clr_in();
      bus.rs_i[2] = 5'd20;
      bus.rs_i[0] = 5'd1;
      #1;
      chk("t2_ready_next", 64'(bus.alloc_ready_o), 64'd1);
      chk("t2_usage_next", 64'(bus.usage_o), 64'd7);
      chk("t2_alloc_id", 64'(bus.alloc_id_o), 64'd0);
      chk("t2_rejected_rd_busy", 64'(bus.rs_busy_o[2]), 64'd0);
      chk("t2_retired_rd_busy", 64'(bus.rs_busy_o[0]), 64'd0);

      // Out-of-order write-back, in-order retire
      do_flush();
      bus.rs_i = '0;
      for (int i = 0; i < 4; i++) do_alloc(5'(i + 1), 32'h100 + 32'(i));
      set_wb(0, 3, 64'h103); tick(); clr_in();
      chk("t3_cv_after_id3", 64'(bus.commit_valid_o), 64'd0);
      set_wb(1, 1, 64'h101); tick(); clr_in();
      chk("t3_cv_after_id1", 64'(bus.commit_valid_o), 64'd0);
      set_wb(2, 2, 64'h102); tick(); clr_in();
      chk("t3_cv_after_id2", 64'(bus.commit_valid_o), 64'd0);
      set_wb(3, 0, 64'h100); tick(); clr_in();
      chk("t3_cv_after_id0", 64'(bus.commit_valid_o), 64'd3);
      chk("t3_rd0", 64'(bus.commit_rd_o[0]), 64'd1);
      chk("t3_rd1", 64'(bus.commit_rd_o[1]), 64'd2);
      chk("t3_data0", bus.commit_data_o[0], 64'h100);
      bus.commit_ack_i = 2'b11;
      tick(); clr_in();
      chk("t3_cv_second", 64'(bus.commit_valid_o), 64'd3);
      chk("t3_rd0_second", 64'(bus.commit_rd_o[0]), 64'd3);
      chk("t3_rd1_second", 64'(bus.commit_rd_o[1]), 64'd4);
      chk("t3_data0_second", bus.commit_data_o[0], 64'h102);
      chk("t3_payload1_second", 64'(bus.commit_payload_o[1]), 64'h103);

      // Youngest producer selects forwarding; rs=0 is never busy
      do_flush();
      do_alloc(5'd7, 32'h70);
      do_alloc(5'd7, 32'h71);
      do_alloc(5'd0, 32'h72);
      set_wb(0, 0, 64'hA); tick(); clr_in();
      bus.rs_i[1] = 5'd7;
      bus.rs_i[2] = 5'd0;
      #1;
      chk("t4_busy", 64'(bus.rs_busy_o[1]), 64'd1);
      chk("t4_fwd_pending", 64'(bus.rs_fwd_valid_o[1]), 64'd0);
      chk("t4_rs0_busy", 64'(bus.rs_busy_o[2]), 64'd0);
      set_wb(2, 1, 64'hB); tick(); clr_in();
      chk("t4_fwd_valid", 64'(bus.rs_fwd_valid_o[1]), 64'd1);
      chk("t4_fwd_data", bus.rs_fwd_data_o[1], 64'hB);

      // Same-id write-back collision, then write-back to an unallocated id
      do_flush();
      bus.rs_i = '0;
      do_alloc(5'd10, 32'hA0);
      do_alloc(5'd11, 32'hA1);
      do_alloc(5'd12, 32'hA2);
      set_wb(0, 2, 64'h11);
      set_wb(1, 0, 64'hA0);
      set_wb(2, 1, 64'hA1);
      set_wb(3, 2, 64'h33);
      tick(); clr_in();
      chk("t5_cv", 64'(bus.commit_valid_o), 64'd3);
      chk("t5_data1", bus.commit_data_o[1], 64'hA1);
      bus.commit_ack_i = 2'b11;
      tick(); clr_in();
      chk("t5_cv_id2", 64'(bus.commit_valid_o), 64'd1);
      chk("t5_data_id2", bus.commit_data_o[0], 64'h33);
      chk("t5_rd_id2", 64'(bus.commit_rd_o[0]), 64'd12);
      set_wb(0, 5, 64'h55); tick(); clr_in();
      chk("t5_usage_stray_wb", 64'(bus.usage_o), 64'd1);
      chk("t5_cv_stray_wb", 64'(bus.commit_valid_o), 64'd1);
      chk("t5_data_stray_wb", bus.commit_data_o[0], 64'h33);
      bus.commit_ack_i = 2'b01;
      tick(); clr_in();
      chk("t5_usage_empty", 64'(bus.usage_o), 64'd0);

      // Pointer wrap over 20 rounds, then flush overriding alloc/wb/ack
      do_flush();
      for (int r = 0; r < 20; r++) begin
         do_alloc(5'((r % 30) + 1), 32'(r));
         set_wb(r % WB, r % N, 64'(r * 3));
         tick(); clr_in();
         chk("t6_round_data", bus.commit_data_o[0], 64'(r * 3));
         bus.commit_ack_i = 2'b01;
         tick(); clr_in();
      end
      chk("t6_wrap_id", 64'(bus.alloc_id_o), 64'd4);
      chk("t6_wrap_usage", 64'(bus.usage_o), 64'd0);
      do_alloc(5'd9, 32'h90);
      bus.alloc_valid_i   = 1'b1;
      bus.alloc_rd_i      = 5'd9;
      bus.alloc_payload_i = 32'h91;
      set_wb(1, 4, 64'hDD);
      tick(); clr_in();
      chk("t6_pre_flush_id", 64'(bus.alloc_id_o), 64'd6);
      chk("t6_pre_flush_usage", 64'(bus.usage_o), 64'd2);
      chk("t6_pre_flush_cv", 64'(bus.commit_valid_o), 64'd1);
      bus.flush_i         = 1'b1;
      bus.alloc_valid_i   = 1'b1;
      bus.alloc_rd_i      = 5'd9;
      set_wb(0, 5, 64'hEE);
      bus.commit_ack_i    = 2'b01;
      bus.rs_i            = {5'd9, 5'd9, 5'd9};
      tick(); clr_in();
      chk("t6_flush_usage", 64'(bus.usage_o), 64'd0);
      chk("t6_flush_id", 64'(bus.alloc_id_o), 64'd0);
      chk("t6_flush_ready", 64'(bus.alloc_ready_o), 64'd1);
      chk("t6_flush_cv", 64'(bus.commit_valid_o), 64'd0);
      chk("t6_flush_busy", 64'(bus.rs_busy_o), 64'd0);
      chk("t6_flush_fwd", 64'(bus.rs_fwd_valid_o), 64'd0);

      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
